// File: rtl/gpu_pkg.sv
// Shared types and frame geometry for the scanout path.
// The frame is DIM x DIM one-bit pixels, read out in BEAT_W-pixel beats.
package gpu_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} scan_state_t;

    localparam int unsigned FRAME_DIM       = 64;
    localparam int unsigned BEAT_W          = 8;
    localparam int unsigned FRAME_BITS      = FRAME_DIM * FRAME_DIM;
    localparam int unsigned BEATS_PER_ROW   = FRAME_DIM / BEAT_W;
    localparam int unsigned BEATS_PER_FRAME = FRAME_BITS / BEAT_W;
    localparam int unsigned COORD_W         = $clog2(FRAME_DIM);
    localparam int unsigned BEAT_IDX_W      = $clog2(BEATS_PER_FRAME);
    localparam int unsigned ROW_BEAT_W      = $clog2(BEATS_PER_ROW);
    localparam int unsigned BEAT_SHIFT      = $clog2(BEAT_W);
    localparam int unsigned POP_W           = $clog2(BEAT_W) + 1;
    localparam int unsigned COUNT_W         = $clog2(FRAME_BITS) + 1;

endpackage

// File: rtl/pixel_scanout_if.sv
// Valid/ready beat stream from the scanout reader toward the display path.
// Each beat carries BEAT_W pixels plus its frame coordinates.
interface pixel_scanout_if;
    import gpu_pkg::*;

    logic               valid;
    logic               ready;
    logic [BEAT_W-1:0]  data;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               last;

    modport master (output valid, data, x, y, last, input ready);
    modport slave  (input valid, data, x, y, last, output ready);

endinterface

// File: rtl/pixel_scanout_popcount8.sv
// Combinational population count of one output beat.
module popcount8
    import gpu_pkg::*;
(
    input  logic [BEAT_W-1:0] data_i,
    output logic [POP_W-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < BEAT_W; i++) begin
            count_o = count_o + POP_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/pixel_scanout.sv
// Snapshots the rasterizer line buffer on start and streams it row-major as beats,
// counting set pixels in accepted beats and pulsing done after the last one.
module pixel_scanout
    import gpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  n_rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [FRAME_BITS-1:0] line_buffer_i,
    pixel_scanout_if.master       out_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [COUNT_W-1:0]    pixel_count_o
);

    scan_state_t             state_q;
    logic [FRAME_BITS-1:0]   snap_q;
    logic [BEAT_IDX_W-1:0]   beat_q;
    logic [COUNT_W-1:0]      count_q;
    logic [POP_W-1:0]        beat_ones;
    logic                    final_beat;
    logic                    xfer;

    // All beat fields derive from registered state, so they hold while ready is low.
    assign final_beat   = (beat_q == BEAT_IDX_W'(BEATS_PER_FRAME - 1));
    assign out_if.valid = (state_q == STREAM);
    assign out_if.data  = snap_q[{beat_q, BEAT_SHIFT'(0)} +: BEAT_W];
    assign out_if.x     = {beat_q[ROW_BEAT_W-1:0], BEAT_SHIFT'(0)};
    assign out_if.y     = beat_q[BEAT_IDX_W-1 -: COORD_W];
    assign out_if.last  = out_if.valid && final_beat;
    assign xfer         = out_if.valid && out_if.ready;

    assign busy_o        = (state_q == STREAM);
    assign done_o        = (state_q == DONE);
    assign pixel_count_o = count_q;

    popcount8 u_popcount8 (
        .data_i  (out_if.data),
        .count_o (beat_ones)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
            snap_q  <= '0;
            beat_q  <= '0;
            count_q <= '0;
        end else if (abort_i) begin
            // Partial count and beat index are kept for inspection after a cancel.
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        snap_q  <= line_buffer_i;
                        beat_q  <= '0;
                        count_q <= '0;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        count_q <= count_q + COUNT_W'(beat_ones);
                        if (final_beat) begin
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_q + BEAT_IDX_W'(1);
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
